// File: rtl/btc_host_link.sv
// rtl/btc_host_link.sv - host controller for the byte-wide miner-core link (serves header, collects hash)
// Optional idle-handshake watchdog: define HOST_TIMEOUT_EN.
module btc_host_link #(
  parameter int HDR_BYTES      = 80,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [6:0]   wr_addr,
  input  logic [7:0]   wr_data,
  input  logic         go,
  output logic         busy,
  output logic         result_valid,
  output logic [255:0] hash,
  output logic         overrun,
  output logic         timeout,
  output logic         dev_start,
  output logic         dev_rdy,
  output logic [7:0]   dev_din,
  input  logic         dev_rq,
  input  logic         dev_done,
  input  logic [7:0]   dev_dout
);

  typedef enum logic [1:0] {IDLE, START, FEED, READ} state_t;

  localparam logic [6:0] HDR_END = 7'(HDR_BYTES);

  state_t     state;
  logic [7:0] hdr [HDR_BYTES];
  logic [6:0] ptr;
  logic [4:0] cnt;
  logic       xfer;

  assign xfer = dev_rq & dev_rdy;

  // Header storage is deliberately not reset so a reset mid-run keeps the loaded block.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE && wr_addr < HDR_END)
      hdr[wr_addr] <= wr_data;
  end

`ifdef HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd;
  logic        timeout_q;
  assign timeout = timeout_q;
`else
  // Watchdog not built; the parameter stays for a uniform interface.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      hash         <= '0;
      overrun      <= 1'b0;
      dev_start    <= 1'b0;
      dev_rdy      <= 1'b0;
      dev_din      <= 8'h00;
      ptr          <= '0;
      cnt          <= '0;
`ifdef HOST_TIMEOUT_EN
      wd           <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      dev_start <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state        <= START;
            busy         <= 1'b1;
            dev_start    <= 1'b1;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            ptr          <= '0;
            cnt          <= '0;
`ifdef HOST_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
          end
        end
        START: state <= FEED;
        FEED: begin
          // done wins over any request pending in the same cycle
          if (dev_done) begin
            state   <= READ;
            dev_rdy <= 1'b0;
          end else if (xfer) begin
            dev_rdy <= 1'b0;
            if (ptr == HDR_END) overrun <= 1'b1;
            else                ptr     <= ptr + 7'd1;
          end else if (dev_rq) begin
            dev_rdy <= 1'b1;
            dev_din <= (ptr < HDR_END) ? hdr[ptr] : 8'h00;
          end else begin
            dev_rdy <= 1'b0;
          end
        end
        READ: begin
          if (xfer) begin
            dev_rdy <= 1'b0;
            hash    <= {hash[247:0], dev_dout};
            cnt     <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state        <= IDLE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end
          end else begin
            dev_rdy <= dev_rq;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef HOST_TIMEOUT_EN
      if (state == START || (state == FEED && dev_done) || xfer)
        wd <= '0;
      else if (state == FEED || state == READ)
        wd <= wd + 16'd1;
      // Later assignments override the handshake decisions above.
      if ((state == FEED || state == READ) && !xfer && !(state == FEED && dev_done)
          && wd == TO_LAST) begin
        timeout_q    <= 1'b1;
        dev_rdy      <= 1'b0;
        state        <= IDLE;
        busy         <= 1'b0;
        result_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/btc_host_link.md
# btc_host_link

Host-side controller for the byte-wide miner-core link. It holds an 80-byte block header loaded by the system and issues the one-cycle start. It answers each byte request from the SHA256d core with the next header byte, then collects the 32 hash result bytes the core returns under the same rq/rdy handshake. It sits between the system bus and the core's `start`/`rdy`/`rq`/`done`/data pins, all in one clock domain.

## Interface
- `HDR_BYTES`, 80, header length in bytes served before the overrun rule applies.
- `TIMEOUT_CYCLES`, 4096, idle-handshake watchdog limit; used only with `HOST_TIMEOUT_EN`.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `wr_en`  in  1  header byte write strobe
- `wr_addr`  in  7  header byte index
- `wr_data`  in  8  header byte
- `go`  in  1  start-request pulse
- `busy`  out  1  high whenever state is not IDLE
- `result_valid`  out  1  `hash` holds a complete result
- `hash`  out  256  result; first received byte is [255:248]
- `overrun`  out  1  sticky; core requested more than HDR_BYTES bytes
- `timeout`  out  1  sticky watchdog flag; constant 0 without macro
- `dev_start`  out  1  to core start
- `dev_rdy`  out  1  to core rdy
- `dev_din`  out  8  header byte to core
- `dev_rq`  in  1  from core rq
- `dev_done`  in  1  from core done
- `dev_dout`  in  8  result byte from core

## Operation
- Header buffer: HDR_BYTES×8 storage, not reset. A write lands when `wr_en` is high, state is IDLE, and `wr_addr` < HDR_BYTES. Writes in any other state or out of range are dropped.
- States and transitions:
  - IDLE to START when `go` is high. On that entry, clear `result_valid`, `overrun` and `timeout`, and zero `ptr`/`cnt`. `go` in any other state is ignored.
  - START drives `dev_start`=1 for exactly one cycle, then moves to FEED.
  - FEED serves header bytes. `dev_done` high moves it to READ with `dev_rdy` cleared; this takes priority over any request pending in the same cycle.
  - READ collects result bytes. On the 32nd capture it moves to IDLE and sets `result_valid`.
- Handshake (both phases):
  - `dev_rq`=1 and `dev_rdy`=0 → set `dev_rdy`=1 next cycle.
  - A transfer occurs at any edge where `dev_rq` and `dev_rdy` are both 1. At that edge, clear `dev_rdy`.
  - `dev_rdy`=1 and `dev_rq`=0 → withdraw `dev_rdy` with no transfer.
- FEED transfer:
  - `dev_din` = buf[`ptr`] while `ptr` < HDR_BYTES, otherwise 0x00.
  - `ptr` increments at each transfer and saturates at HDR_BYTES.
  - A transfer with `ptr` = HDR_BYTES sets `overrun`.
- READ transfer: `hash` <= {`hash`[247:0], `dev_dout`}; `cnt` (5-bit) increments. The transfer where `cnt`=31 is the final one.

## Timing
- Reset values: state IDLE, `dev_start`=0, `dev_rdy`=0, `dev_din`=0, `busy`=0, `result_valid`=0, `hash`=0, `overrun`=0, `timeout`=0, `ptr`=0, `cnt`=0.
- Reset asserted mid-operation returns the block to IDLE immediately; header contents are retained.
- `go` sampled at edge E: `busy`=1 and `dev_start`=1 after E; `dev_start`=0 after E+1.
- `dev_rdy` rises one cycle after `dev_rq` is seen. With the companion core, one byte moves every 3 cycles, so the 32-byte readback takes about 96 cycles.
- `dev_din` is held stable for the entire time `dev_rdy`=1.
- `result_valid` rises at the edge of the 32nd capture; `busy` falls at the same edge.

## Configuration
- `HOST_TIMEOUT_EN` defined:
  - A 16-bit counter runs in FEED and READ. It clears on every transfer and on entry to either state.
  - When it reaches TIMEOUT_CYCLES: set `timeout`, drive `dev_rdy`=0, and return to IDLE with `result_valid`=0.
- `HOST_TIMEOUT_EN` undefined: no counter is built; `timeout` is tied to 0 and the block waits indefinitely.

## Test plan
- Load buf[i]=i for i=0..79, pulse `go`, model core requests 80 bytes → `dev_din` sequence is 0x00..0x4F in order, `overrun`=0, and `dev_start` is high for exactly 1 cycle.
- Model core asserts `dev_done` and returns bytes 0xA0..0xBF → `hash`[255:248]=0xA0, `hash`[7:0]=0xBF; `result_valid`=1 and `busy`=0 on the same edge.
- Core requests an 81st byte → `dev_din`=0x00 and `overrun`=1, which stays set until the next `go`.
- During FEED, write 0xFF to addr 0 and pulse `go` → both ignored; after completion, a rerun serves the original buf[0]=0x00.
- Assert `rst_n`=0 during READ at `cnt`=10 → all outputs return to reset values; a rerun with the same header produces the correct result.
- With `HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, hold `dev_rq`=0 in FEED → `timeout`=1 16 cycles after entry, state back in IDLE.
